ahb_resp_mux: RTL and testbench

- Data-phase response stage directly downstream of the AHB address decoder.
- Registers the decoder's one-hot slave select at each address-phase acceptance, then steers the selected slave's HRDATA/HREADY/HRESP back to the master.
- Contains the built-in default slave: two-cycle ERROR response for active transfers to unmapped space.
- Keeps a saturating count of default-slave errors for debug.

---
 rtl/ahb_pkg.sv | 37 +++
 rtl/ahb_default_slave.sv | 65 ++++++
 rtl/ahb_resp_mux.sv | 88 ++++++++
 tb/tb_ahb_resp_mux.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/ahb_pkg.sv
// Shared AHB encodings, default-slave state type and slave index constants
// for the data-phase response path.
package ahb_pkg;

    localparam int AHB_DATA_BITS = 32;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [1:0] HRESP_OKAY  = 2'b00;
    localparam logic [1:0] HRESP_ERROR = 2'b01;
    localparam logic [1:0] HRESP_RETRY = 2'b10;
    localparam logic [1:0] HRESP_SPLIT = 2'b11;

    // Bit positions in the one-hot select vector; bit 0 is the built-in default slave.
    localparam int SLV_DEFAULT = 0;
    localparam int SLV_1       = 1;
    localparam int SLV_2       = 2;
    localparam int SLV_3       = 3;
    localparam int SLV_4       = 4;
    localparam int SLV_5       = 5;
    localparam int SLV_6       = 6;
    localparam int SLV_7       = 7;

    typedef enum logic [1:0] {
        D_IDLE = 2'd0,
        D_ERR1 = 2'd1,
        D_ERR2 = 2'd2
    } dflt_state_t;

    function automatic logic trans_active(input logic [1:0] htrans);
        return (htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ);
    endfunction

endpackage

// File: rtl/ahb_default_slave.sv
// Built-in default slave: two-cycle ERROR for active transfers to unmapped
// space, plus a saturating count of those errors.
module ahb_default_slave
    import ahb_pkg::*;
#(
    parameter int ERRCNT_W = 8
) (
    input  logic                HCLK,
    input  logic                HRESET,
    input  logic                sel_default,
    input  logic [1:0]          HTRANS,
    input  logic                HREADY,
    output logic                dflt_hready,
    output logic [1:0]          dflt_hresp,
    output logic [ERRCNT_W-1:0] err_cnt
);

    dflt_state_t         state_q;
    dflt_state_t         state_d;
    logic                start_err;
    logic [ERRCNT_W-1:0] cnt_q;

    // An address phase is only accepted when the global HREADY is high.
    assign start_err = HREADY && sel_default && trans_active(HTRANS);

    always_comb begin
        state_d     = state_q;
        dflt_hready = 1'b1;
        dflt_hresp  = HRESP_OKAY;
        case (state_q)
            D_IDLE: begin
                if (start_err) state_d = D_ERR1;
            end
            D_ERR1: begin
                dflt_hready = 1'b0;
                dflt_hresp  = HRESP_ERROR;
                state_d     = D_ERR2;
            end
            D_ERR2: begin
                dflt_hready = 1'b1;
                dflt_hresp  = HRESP_ERROR;
                state_d     = start_err ? D_ERR1 : D_IDLE;
            end
            default: begin
                state_d = D_IDLE;
            end
        endcase
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q <= D_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            // D_ERR1 always exits to D_ERR2, so next==D_ERR1 marks a fresh entry.
            if ((state_d == D_ERR1) && (cnt_q != '1)) begin
                cnt_q <= cnt_q + ERRCNT_W'(1);
            end
        end
    end

    assign err_cnt = cnt_q;

endmodule

// File: rtl/ahb_resp_mux.sv
// Data-phase response stage: registers the decoder select at each accepted
// address phase and steers the selected slave's response back to the master.
module ahb_resp_mux
    import ahb_pkg::*;
#(
    parameter int NUM_SLV  = 8,
    parameter int DATA_W   = AHB_DATA_BITS,
    parameter int ERRCNT_W = 8
) (
    input  logic                        HCLK,
    input  logic                        HRESET,
    input  logic [NUM_SLV-1:0]          HSEL,
    input  logic [1:0]                  HTRANS,
    input  logic [NUM_SLV*DATA_W-1:0]   HRDATA_S,
    input  logic [NUM_SLV-1:0]          HREADY_S,
    input  logic [NUM_SLV*2-1:0]        HRESP_S,
    output logic [DATA_W-1:0]           HRDATA,
    output logic                        HREADY,
    output logic [1:0]                  HRESP,
    output logic [ERRCNT_W-1:0]         err_cnt
);

    localparam logic [NUM_SLV-1:0] DSEL_DFLT = NUM_SLV'(1) << SLV_DEFAULT;

    // Handshake: an address phase (HSEL/HTRANS) is accepted on any rising
    // edge where HREADY is 1; while HREADY is 0 the current data phase is
    // stretched and the pending address phase is neither sampled nor lost.
    logic [NUM_SLV-1:0] dsel_q;
    logic [NUM_SLV-1:0] hsel_capture;
    logic               hsel_onehot;
    logic               sel_default;
    logic               dflt_hready;
    logic [1:0]         dflt_hresp;
    logic [DATA_W-1:0]  rdata_mux;
    logic               ready_mux;
    logic [1:0]         resp_mux;

    assign hsel_onehot  = (HSEL != '0) && ((HSEL & (HSEL - NUM_SLV'(1))) == '0);
    assign hsel_capture = hsel_onehot ? HSEL : DSEL_DFLT;
    assign sel_default  = hsel_capture[SLV_DEFAULT];

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            dsel_q <= DSEL_DFLT;
        end else if (HREADY) begin
            dsel_q <= hsel_capture;
        end
    end

    ahb_default_slave #(
        .ERRCNT_W (ERRCNT_W)
    ) u_default_slave (
        .HCLK        (HCLK),
        .HRESET      (HRESET),
        .sel_default (sel_default),
        .HTRANS      (HTRANS),
        .HREADY      (HREADY),
        .dflt_hready (dflt_hready),
        .dflt_hresp  (dflt_hresp),
        .err_cnt     (err_cnt)
    );

    // dsel_q is one-hot by construction, so an AND-OR mux is sufficient.
    always_comb begin
        rdata_mux = '0;
        ready_mux = 1'b0;
        resp_mux  = '0;
        for (int k = 0; k < NUM_SLV; k++) begin
            if (dsel_q[k]) begin
                rdata_mux = rdata_mux | HRDATA_S[k*DATA_W +: DATA_W];
                ready_mux = ready_mux | HREADY_S[k];
                resp_mux  = resp_mux | HRESP_S[k*2 +: 2];
            end
        end
    end

    always_comb begin
        HRDATA = rdata_mux;
        HREADY = ready_mux;
        HRESP  = resp_mux;
        if (dsel_q[SLV_DEFAULT]) begin
            HRDATA = '0;
            HREADY = dflt_hready;
            HRESP  = dflt_hresp;
        end
    end

endmodule

// File: tb/tb_ahb_resp_mux.sv
// Directed bench for ahb_resp_mux: the driver pushes each cycle's expected
// response into a queue and a negedge monitor pops and compares it.
module tb_ahb_resp_mux;

    localparam int NS = 8;
    localparam int DW = 32;
    localparam int CW = 8;
    localparam int W  = 1 + 2 + DW + CW;

    logic             clk;
    logic             rst;
    logic [NS-1:0]    hsel;
    logic [1:0]       htrans;
    logic [NS*DW-1:0] hrdata_s;
    logic [NS-1:0]    hready_s;
    logic [NS*2-1:0]  hresp_s;
    logic [DW-1:0]    hrdata;
    logic             hready;
    logic [1:0]       hresp;
    logic [CW-1:0]    err_cnt;

    logic [W-1:0] exp_q[$];
    string        name_q[$];
    int           checks;
    int           passed;
    int           failed;

    ahb_resp_mux #(
        .NUM_SLV  (NS),
        .DATA_W   (DW),
        .ERRCNT_W (CW)
    ) dut (
        .HCLK     (clk),
        .HRESET   (rst),
        .HSEL     (hsel),
        .HTRANS   (htrans),
        .HRDATA_S (hrdata_s),
        .HREADY_S (hready_s),
        .HRESP_S  (hresp_s),
        .HRDATA   (hrdata),
        .HREADY   (hready),
        .HRESP    (hresp),
        .err_cnt  (err_cnt)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle: address-phase inputs plus the expected response seen in this cycle.
    task automatic step(input logic rst_i, input logic [NS-1:0] hsel_i, input logic [1:0] htr_i,
                        input logic [NS-1:0] rdy_i, input logic e_rdy, input logic [1:0] e_resp,
                        input logic [DW-1:0] e_data, input logic [CW-1:0] e_cnt, input string nm);
        rst      = rst_i;
        hsel     = hsel_i;
        htrans   = htr_i;
        hready_s = rdy_i;
        exp_q.push_back({e_rdy, e_resp, e_data, e_cnt});
        name_q.push_back(nm);
        @(posedge clk);
        #1;
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            logic [W-1:0] exp_v;
            logic [W-1:0] got_v;
            string        nm;
            exp_v = exp_q.pop_front();
            nm    = name_q.pop_front();
            got_v = {hready, hresp, hrdata, err_cnt};
            checks++;
            if (got_v === exp_v) begin
                passed++;
            end else begin
                failed++;
                $display("FAIL %s: got hready=%b hresp=%b hrdata=%h err_cnt=%0d, expected hready=%b hresp=%b hrdata=%h err_cnt=%0d",
                         nm, got_v[W-1], got_v[W-2 -: 2], got_v[W-4 -: DW], got_v[CW-1:0],
                         exp_v[W-1], exp_v[W-2 -: 2], exp_v[W-4 -: DW], exp_v[CW-1:0]);
            end
        end
    end

    localparam logic [1:0] T_IDLE = 2'b00;
    localparam logic [1:0] T_NSEQ = 2'b10;
    localparam logic [1:0] T_SEQ  = 2'b11;
    localparam logic [NS-1:0] RDY_ALL = 8'hFE;
    localparam logic [NS-1:0] RDY_S3W = 8'hF6;

    initial begin
        int ec;
        checks = 0;
        passed = 0;
        failed = 0;
        // Entry 0 carries poison values: the default slave must never expose them.
        for (int k = 0; k < NS; k++) begin
            hrdata_s[k*DW +: DW] = 32'h1111_1111 * k;
        end
        hrdata_s[0*DW +: DW] = 32'hFFFF_FFFF;
        hrdata_s[2*DW +: DW] = 32'hDEAD_BEEF;
        hresp_s  = '0;
        hresp_s[0*2 +: 2] = 2'b11;
        hresp_s[5*2 +: 2] = 2'b10;
        hready_s = RDY_ALL;
        hsel     = '0;
        htrans   = T_IDLE;
        rst      = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        step(1'b1, 8'h04, T_NSEQ, RDY_ALL, 1'b1, 2'b00, 32'h0, 8'd0, "reset_hold");
        step(1'b0, 8'h04, T_NSEQ, RDY_ALL, 1'b1, 2'b00, 32'h0, 8'd0, "reset_release");
        step(1'b0, 8'h00, T_IDLE, RDY_ALL, 1'b1, 2'b00, 32'hDEAD_BEEF, 8'd0, "read_s2");
        step(1'b0, 8'h08, T_NSEQ, RDY_ALL, 1'b1, 2'b00, 32'h0, 8'd0, "idle_to_s3_addr");
        step(1'b0, 8'h02, T_NSEQ, RDY_S3W, 1'b0, 2'b00, 32'h3333_3333, 8'd0, "s3_wait1");
        step(1'b0, 8'h02, T_NSEQ, RDY_S3W, 1'b0, 2'b00, 32'h3333_3333, 8'd0, "s3_wait2");
        step(1'b0, 8'h02, T_NSEQ, RDY_S3W, 1'b0, 2'b00, 32'h3333_3333, 8'd0, "s3_wait3");
        step(1'b0, 8'h02, T_NSEQ, RDY_ALL, 1'b1, 2'b00, 32'h3333_3333, 8'd0, "s3_done");
        step(1'b0, 8'h20, T_SEQ,  RDY_ALL, 1'b1, 2'b00, 32'h1111_1111, 8'd0, "read_s1");
        step(1'b0, 8'h01, T_NSEQ, RDY_ALL, 1'b1, 2'b10, 32'h5555_5555, 8'd0, "read_s5_retry");
        step(1'b0, 8'h00, T_IDLE, RDY_ALL, 1'b0, 2'b01, 32'h0, 8'd1, "unmapped_err1");
        step(1'b0, 8'h01, T_IDLE, RDY_ALL, 1'b1, 2'b01, 32'h0, 8'd1, "unmapped_err2");
        step(1'b0, 8'h10, T_NSEQ, RDY_ALL, 1'b1, 2'b00, 32'h0, 8'd1, "default_idle_okay");
        step(1'b0, 8'h06, T_NSEQ, RDY_ALL, 1'b1, 2'b00, 32'h4444_4444, 8'd1, "read_s4");
        step(1'b1, 8'h01, T_NSEQ, RDY_ALL, 1'b0, 2'b01, 32'h0, 8'd2, "illegal_sel_err1");
        step(1'b0, 8'h00, T_IDLE, RDY_ALL, 1'b1, 2'b00, 32'h0, 8'd0, "reset_in_err1");

        // Back-to-back unmapped NONSEQ transfers, chaining ERR2 -> ERR1.
        step(1'b0, 8'h01, T_NSEQ, RDY_ALL, 1'b1, 2'b00, 32'h0, 8'd0, "b2b_first_addr");
        for (int i = 1; i <= 260; i++) begin
            ec = (i > 255) ? 255 : i;
            step(1'b0, 8'h01, T_NSEQ, RDY_ALL, 1'b0, 2'b01, 32'h0, CW'(ec), "b2b_err1");
            step(1'b0, (i < 260) ? 8'h01 : 8'h02, T_NSEQ, RDY_ALL, 1'b1, 2'b01, 32'h0, CW'(ec), "b2b_err2");
        end
        step(1'b0, 8'h00, T_IDLE, RDY_ALL, 1'b1, 2'b00, 32'h1111_1111, 8'd255, "after_sat_s1");

        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() == 0) begin
            passed++;
        end else begin
            failed++;
            $display("FAIL queue_drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
